microcode_sequencer: RTL and testbench

Upstream stage of the microcode ROM. Accepts opcode bytes from the instruction-fetch unit and handles the 0xCB prefix page. Produces the registered 9-bit microcode address (`upc`) that indexes the opcode/subop tables. Walks multi-step instructions using next-address and last-step fields fed back from the ROM's control word, and sequences HALT and interrupt entry.

---
 rtl/microcode_sequencer.sv | 122 ++++++++++++
 tb/tb_microcode_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/microcode_sequencer.sv
// rtl/microcode_sequencer.sv - opcode fetch, CB prefix, step walk, HALT and interrupt entry
// Produces the registered microcode address feeding the opcode/subop ROM tables.
module microcode_sequencer #(
  parameter logic [8:0] INT_UPC = 9'h0D3,
  parameter logic [7:0] CB_BYTE = 8'hCB
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] instr_byte,
  input  logic       instr_valid,
  input  logic [8:0] ucode_next,
  input  logic       ucode_last,
  input  logic       ucode_halt,
  input  logic       ucode_stall,
  input  logic       irq_pending,
  input  logic       ime,
  output logic [8:0] upc,
  output logic       upc_valid,
  output logic       fetch_req,
  output logic       int_ack,
  output logic [3:0] ucode_step
);

  typedef enum logic [1:0] {
    ST_FETCH    = 2'd0,
    ST_CB_FETCH = 2'd1,
    ST_EXEC     = 2'd2,
    ST_HALT     = 2'd3
  } state_t;

  state_t     state_q;
  logic [8:0] upc_q;
  logic       upc_valid_q;
  logic       fetch_req_q;
  logic       int_ack_q;
  logic [3:0] step_q;
  logic [3:0] step_d;
  logic       accept;

  // fetch_req is registered, so a byte is only taken once the request is visible
  assign accept = fetch_req_q && instr_valid;
  assign step_d = (step_q == 4'hF) ? step_q : step_q + 4'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_FETCH;
      upc_q       <= 9'd0;
      upc_valid_q <= 1'b0;
      fetch_req_q <= 1'b0;
      int_ack_q   <= 1'b0;
      step_q      <= 4'd0;
    end else begin
      int_ack_q <= 1'b0;
      unique case (state_q)
        ST_FETCH: begin
          fetch_req_q <= 1'b1;
          if (accept) begin
            if (instr_byte == CB_BYTE) begin
              state_q <= ST_CB_FETCH;
            end else begin
              upc_q       <= {1'b0, instr_byte};
              step_q      <= 4'd0;
              upc_valid_q <= 1'b1;
              fetch_req_q <= 1'b0;
              state_q     <= ST_EXEC;
            end
          end
        end
        ST_CB_FETCH: begin
          if (accept) begin
            upc_q       <= {1'b1, instr_byte};
            step_q      <= 4'd0;
            upc_valid_q <= 1'b1;
            fetch_req_q <= 1'b0;
            state_q     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (!ucode_stall) begin
            if (!ucode_last) begin
              upc_q  <= ucode_next;
              step_q <= step_d;
            end else if (ucode_halt) begin
              upc_valid_q <= 1'b0;
              state_q     <= ST_HALT;
            end else if (irq_pending && ime) begin
              upc_q     <= INT_UPC;
              step_q    <= 4'd0;
              int_ack_q <= 1'b1;
            end else begin
              upc_valid_q <= 1'b0;
              fetch_req_q <= 1'b1;
              state_q     <= ST_FETCH;
            end
          end
        end
        ST_HALT: begin
          if (irq_pending) begin
            if (ime) begin
              upc_q       <= INT_UPC;
              step_q      <= 4'd0;
              int_ack_q   <= 1'b1;
              upc_valid_q <= 1'b1;
              state_q     <= ST_EXEC;
            end else begin
              fetch_req_q <= 1'b1;
              state_q     <= ST_FETCH;
            end
          end
        end
        default: state_q <= ST_FETCH;
      endcase
    end
  end

  assign upc        = upc_q;
  assign upc_valid  = upc_valid_q;
  assign fetch_req  = fetch_req_q;
  assign int_ack    = int_ack_q;
  assign ucode_step = step_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// tb/tb_microcode_sequencer.sv - scoreboard bench for microcode_sequencer
module tb_microcode_sequencer;

  logic       clk;
  logic       reset_n;
  logic [7:0] instr_byte;
  logic       instr_valid;
  logic [8:0] ucode_next;
  logic       ucode_last;
  logic       ucode_halt;
  logic       ucode_stall;
  logic       irq_pending;
  logic       ime;
  logic [8:0] upc;
  logic       upc_valid;
  logic       fetch_req;
  logic       int_ack;
  logic [3:0] ucode_step;

  typedef struct {
    logic [8:0] upc;
    logic [3:0] step;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;

  microcode_sequencer #(.INT_UPC(9'h0D3), .CB_BYTE(8'hCB)) dut (
    .clk(clk), .reset_n(reset_n), .instr_byte(instr_byte), .instr_valid(instr_valid),
    .ucode_next(ucode_next), .ucode_last(ucode_last), .ucode_halt(ucode_halt),
    .ucode_stall(ucode_stall), .irq_pending(irq_pending), .ime(ime),
    .upc(upc), .upc_valid(upc_valid), .fetch_req(fetch_req), .int_ack(int_ack),
    .ucode_step(ucode_step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fetch();
    int n = 0;
    while (fetch_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (fetch_req !== 1'b1) begin failures++; $display("FAIL fetch_timeout: fetch_req=%b required 1", fetch_req); end
  endtask

  task automatic fetch_byte(input logic [7:0] b);
    wait_fetch();
    ucode_last  = 1'b0;
    ucode_halt  = 1'b0;
    instr_valid = 1'b1;
    instr_byte  = b;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic pop_check(input string name);
    e = sb.pop_front();
    checks++;
    if (upc !== e.upc || ucode_step !== e.step) begin
      failures++;
      $display("FAIL %s: upc=%h step=%0d required upc=%h step=%0d", name, upc, ucode_step, e.upc, e.step);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    checks++; if (upc !== 9'h000) begin failures++; $display("FAIL rst_upc: %h required 000", upc); end
    checks++; if (upc_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: %b required 0", upc_valid); end
    checks++; if (fetch_req !== 1'b0) begin failures++; $display("FAIL rst_fetch: %b required 0", fetch_req); end
    checks++; if (int_ack !== 1'b0) begin failures++; $display("FAIL rst_ack: %b required 0", int_ack); end
    checks++; if (ucode_step !== 4'd0) begin failures++; $display("FAIL rst_step: %0d required 0", ucode_step); end
    reset_n = 1'b1;
    checks++; if (fetch_req !== 1'b0) begin failures++; $display("FAIL rst_fetch_early: %b required 0", fetch_req); end
    tick();
    checks++; if (fetch_req !== 1'b1) begin failures++; $display("FAIL rst_fetch_rise: %b required 1", fetch_req); end
  endtask

  task automatic test_basic();
    sb.push_back('{9'h03E, 4'd0});
    sb.push_back('{9'h101, 4'd1});
    ucode_next = 9'h101;
    fetch_byte(8'h3E);
    checks++; if (upc_valid !== 1'b1) begin failures++; $display("FAIL basic_valid: %b required 1", upc_valid); end
    checks++; if (fetch_req !== 1'b0) begin failures++; $display("FAIL basic_nofetch: %b required 0", fetch_req); end
    pop_check("basic_step0");
    tick();
    pop_check("basic_step1");
    ucode_last = 1'b1;
    tick();
    ucode_last = 1'b0;
    checks++; if (fetch_req !== 1'b1 || upc_valid !== 1'b0) begin
      failures++; $display("FAIL basic_refetch: fetch_req=%b upc_valid=%b required 1 0", fetch_req, upc_valid); end
  endtask

  task automatic test_prefix();
    wait_fetch();
    instr_valid = 1'b1;
    instr_byte  = 8'hCB;
    tick();
    checks++; if (upc_valid !== 1'b0 || fetch_req !== 1'b1) begin
      failures++; $display("FAIL prefix_gap: upc_valid=%b fetch_req=%b required 0 1", upc_valid, fetch_req); end
    instr_byte = 8'h37;
    sb.push_back('{9'h137, 4'd0});
    tick();
    instr_valid = 1'b0;
    pop_check("prefix_37");
    checks++; if (upc[8] !== 1'b1 || upc_valid !== 1'b1) begin
      failures++; $display("FAIL prefix_page: upc8=%b valid=%b required 1 1", upc[8], upc_valid); end
    ucode_last = 1'b1;
    tick();
    ucode_last = 1'b0;
    wait_fetch();
    instr_valid = 1'b1;
    instr_byte  = 8'hCB;
    tick();
    sb.push_back('{9'h1CB, 4'd0});
    tick();
    instr_valid = 1'b0;
    pop_check("prefix_cbcb");
    ucode_last = 1'b1;
    tick();
    ucode_last = 1'b0;
  endtask

  task automatic test_stall();
    ucode_next = 9'h055;
    fetch_byte(8'h10);
    tick();
    ucode_stall = 1'b1;
    ucode_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{9'h055, 4'd1});
      tick();
      pop_check("stall_hold");
      checks++; if (fetch_req !== 1'b0 || upc_valid !== 1'b1) begin
        failures++; $display("FAIL stall_state: fetch_req=%b upc_valid=%b required 0 1", fetch_req, upc_valid); end
    end
    ucode_stall = 1'b0;
    tick();
    ucode_last = 1'b0;
    checks++; if (fetch_req !== 1'b1) begin failures++; $display("FAIL stall_release: fetch_req=%b required 1", fetch_req); end
  endtask

  task automatic test_irq();
    irq_pending = 1'b1;
    ime         = 1'b1;
    repeat (2) tick();
    checks++; if (int_ack !== 1'b0 || upc_valid !== 1'b0) begin
      failures++; $display("FAIL irq_in_fetch: int_ack=%b upc_valid=%b required 0 0", int_ack, upc_valid); end
    irq_pending = 1'b0;
    fetch_byte(8'h20);
    ucode_last  = 1'b1;
    irq_pending = 1'b1;
    sb.push_back('{9'h0D3, 4'd0});
    tick();
    pop_check("irq_upc");
    checks++; if (int_ack !== 1'b1 || upc_valid !== 1'b1) begin
      failures++; $display("FAIL irq_ack: int_ack=%b upc_valid=%b required 1 1", int_ack, upc_valid); end
    ucode_last  = 1'b0;
    irq_pending = 1'b0;
    ucode_next  = 9'h0D4;
    sb.push_back('{9'h0D4, 4'd1});
    tick();
    pop_check("irq_routine");
    checks++; if (int_ack !== 1'b0) begin failures++; $display("FAIL irq_pulse: int_ack=%b required 0", int_ack); end
    ucode_last = 1'b1;
    ime        = 1'b0;
    tick();
    checks++; if (fetch_req !== 1'b1) begin failures++; $display("FAIL irq_end: fetch_req=%b required 1", fetch_req); end
    fetch_byte(8'h21);
    ucode_last  = 1'b1;
    irq_pending = 1'b1;
    tick();
    irq_pending = 1'b0;
    ucode_last  = 1'b0;
    checks++; if (fetch_req !== 1'b1 || int_ack !== 1'b0 || upc_valid !== 1'b0) begin
      failures++; $display("FAIL irq_ime0: fetch_req=%b int_ack=%b valid=%b required 1 0 0", fetch_req, int_ack, upc_valid); end
  endtask

  task automatic test_halt();
    fetch_byte(8'h76);
    ucode_last = 1'b1;
    ucode_halt = 1'b1;
    tick();
    ucode_last = 1'b0;
    ucode_halt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++; if (upc_valid !== 1'b0 || fetch_req !== 1'b0) begin
        failures++; $display("FAIL halt_idle%0d: valid=%b fetch_req=%b required 0 0", i, upc_valid, fetch_req); end
      tick();
    end
    irq_pending = 1'b1;
    ime         = 1'b0;
    tick();
    irq_pending = 1'b0;
    checks++; if (fetch_req !== 1'b1 || int_ack !== 1'b0) begin
      failures++; $display("FAIL halt_resume: fetch_req=%b int_ack=%b required 1 0", fetch_req, int_ack); end
    fetch_byte(8'h76);
    ucode_last = 1'b1;
    ucode_halt = 1'b1;
    tick();
    ucode_last = 1'b0;
    ucode_halt = 1'b0;
    repeat (3) tick();
    irq_pending = 1'b1;
    ime         = 1'b1;
    sb.push_back('{9'h0D3, 4'd0});
    tick();
    irq_pending = 1'b0;
    ime         = 1'b0;
    pop_check("halt_int_upc");
    checks++; if (int_ack !== 1'b1 || upc_valid !== 1'b1) begin
      failures++; $display("FAIL halt_int_ack: int_ack=%b valid=%b required 1 1", int_ack, upc_valid); end
    ucode_last = 1'b1;
    tick();
    ucode_last = 1'b0;
  endtask

  task automatic test_saturation();
    ucode_next = 9'h150;
    sb.push_back('{9'h050, 4'd0});
    fetch_byte(8'h50);
    pop_check("sat_first");
    for (int i = 1; i <= 20; i++) begin
      sb.push_back('{9'h150, (i > 15) ? 4'd15 : 4'(i)});
      tick();
      pop_check("sat_step");
    end
    ucode_last = 1'b1;
    tick();
    ucode_last = 1'b0;
  endtask

  task automatic test_async_reset();
    ucode_next = 9'h0AA;
    fetch_byte(8'h40);
    repeat (5) tick();
    checks++; if (ucode_step !== 4'd5 || upc !== 9'h0AA) begin
      failures++; $display("FAIL areset_pre: step=%0d upc=%h required 5 0aa", ucode_step, upc); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (upc !== 9'h000 || upc_valid !== 1'b0 || fetch_req !== 1'b0 || ucode_step !== 4'd0 || int_ack !== 1'b0) begin
      failures++; $display("FAIL areset_clear: upc=%h valid=%b fetch=%b step=%0d ack=%b required 000 0 0 0 0",
                           upc, upc_valid, fetch_req, ucode_step, int_ack); end
    #1;
    reset_n = 1'b1;
    wait_fetch();
  endtask

  initial begin
    reset_n     = 1'b0;
    instr_byte  = 8'h00;
    instr_valid = 1'b0;
    ucode_next  = 9'h000;
    ucode_last  = 1'b0;
    ucode_halt  = 1'b0;
    ucode_stall = 1'b0;
    irq_pending = 1'b0;
    ime         = 1'b0;
    test_reset();
    test_basic();
    test_prefix();
    test_stall();
    test_irq();
    test_halt();
    test_saturation();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL sb_drain: %0d entries left required 0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
